udm_frame_decoder: RTL and testbench

Byte-level frame parser for the UART debug module. It consumes the byte stream from the autobaud UART receiver (done tick, data byte, lock and bit-period outputs) and decodes framed read/write commands. Each decoded command becomes a single-word bus request held under a req/ack handshake. It sits between the UART receiver and the debug bus master. It handles sync, escaping, unknown commands, inter-byte timeout and overrun.

---
 rtl/udm_frame_pkg.sv | 35 +++
 rtl/udm_gap_timer.sv | 44 ++++
 rtl/udm_frame_decoder.sv | 163 ++++++++++++++++
 tb/tb_udm_frame_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/udm_frame_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | udm_frame_pkg : shared constants and types for the UDM frame parser |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package udm_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] ESC_BYTE  = 8'h5A;
  localparam logic [7:0] CMD_WR    = 8'h81;
  localparam logic [7:0] CMD_RD    = 8'h82;

  localparam int BITPERIOD_W = 29;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_REQ  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_CMD  = ST_CMD,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA,
    S_REQ  = ST_REQ
  } state_e;

  // Fields arrive LSB first, so each new byte enters at the top.
  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return {b, word[31:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/udm_gap_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | udm_gap_timer : inter-byte silence detector, pulses on expiry       |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module udm_gap_timer
  import udm_frame_pkg::*;
#(
  parameter int MAX_SHIFT = 6,
  parameter int SHIFT_W   = $clog2(MAX_SHIFT + 2),
  parameter int CNT_W     = BITPERIOD_W + MAX_SHIFT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [BITPERIOD_W-1:0] bitperiod_i,
  input  logic [SHIFT_W-1:0]     shift_i,
  output logic                   expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_now;
  logic [CNT_W-1:0] limit;

  // cnt_now is the number of cycles elapsed since the last tick, counting this one.
  always_comb begin
    limit     = CNT_W'(bitperiod_i) << shift_i;
    cnt_now   = clear_i ? '0 : cnt_q + CNT_W'(1);
    cnt_d     = enable_i ? cnt_now : '0;
    expired_o = enable_i && !clear_i && (cnt_now == limit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/udm_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | udm_frame_decoder : UART byte stream to single-word bus requests    |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module udm_frame_decoder
  import udm_frame_pkg::*;
#(
  parameter int TIMEOUT_SHIFT = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   locked_i,
  input  logic [BITPERIOD_W-1:0] bitperiod_bi,
  input  logic                   rx_done_tick_i,
  input  logic [7:0]             rx_data_bi,
  output logic                   req_o,
  output logic                   we_o,
  output logic [31:0]            addr_bo,
  output logic [31:0]            wdata_bo,
  input  logic                   ack_i,
  output logic                   err_tick_o,
  output logic                   overrun_tick_o
);

  localparam int SHIFT_W = $clog2(TIMEOUT_SHIFT + 2);

  state_e      state_q, state_d;
  logic        esc_q, esc_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;

  logic tick_ok;
  logic in_frame;
  logic expired;

  assign tick_ok  = rx_done_tick_i & locked_i;
  assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);

  udm_gap_timer #(
    .MAX_SHIFT (TIMEOUT_SHIFT),
    .SHIFT_W   (SHIFT_W)
  ) u_gap_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (tick_ok),
    .enable_i    (in_frame),
    .bitperiod_i (bitperiod_bi),
    .shift_i     (SHIFT_W'(TIMEOUT_SHIFT)),
    .expired_o   (expired)
  );

  always_comb begin
    state_d = state_q;
    esc_d   = esc_q;
    bcnt_d  = bcnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;

    if (state_q == S_REQ) begin
      // A pending request owns the fields; any arriving byte is lost.
      if (tick_ok) ovr_d = 1'b1;
      if (ack_i) begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    end else if (!locked_i) begin
      state_d = S_IDLE;
      esc_d   = 1'b0;
      bcnt_d  = 2'd0;
    end else if (expired) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
      esc_d   = 1'b0;
      bcnt_d  = 2'd0;
    end else if (rx_done_tick_i) begin
      if (!esc_q && rx_data_bi == SYNC_BYTE) begin
        state_d = S_CMD;
        bcnt_d  = 2'd0;
        esc_d   = 1'b0;
      end else if (!esc_q && rx_data_bi == ESC_BYTE) begin
        esc_d = 1'b1;
      end else begin
        esc_d = 1'b0;
        case (state_q)
          S_CMD: begin
            if (rx_data_bi == CMD_WR) begin
              we_d    = 1'b1;
              bcnt_d  = 2'd0;
              state_d = S_ADDR;
            end else if (rx_data_bi == CMD_RD) begin
              we_d    = 1'b0;
              bcnt_d  = 2'd0;
              state_d = S_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
          S_ADDR: begin
            addr_d = shift_in(addr_q, rx_data_bi);
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_d = we_q ? S_DATA : S_REQ;
              req_d   = !we_q;
            end
          end
          S_DATA: begin
            wdata_d = shift_in(wdata_q, rx_data_bi);
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_d = S_REQ;
              req_d   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      esc_q   <= 1'b0;
      bcnt_q  <= 2'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      esc_q   <= esc_d;
      bcnt_q  <= bcnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign req_o          = req_q;
  assign we_o           = we_q;
  assign addr_bo        = addr_q;
  assign wdata_bo       = wdata_q;
  assign err_tick_o     = err_q;
  assign overrun_tick_o = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_udm_frame_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_udm_frame_decoder : directed self-checking bench for the decoder |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_udm_frame_decoder;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst_i;
  logic        locked_i;
  logic [28:0] bitperiod_bi;
  logic        rx_done_tick_i;
  logic [7:0]  rx_data_bi;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_bo;
  logic [31:0] wdata_bo;
  logic        ack_i;
  logic        err_tick_o;
  logic        overrun_tick_o;

  int n_vec    = 0;
  int n_miss   = 0;
  int err_seen = 0;
  int ovr_seen = 0;
  int err_base;
  int ovr_base;
  bq_t seq;

  always #5 clk = ~clk;

  udm_frame_decoder #(.TIMEOUT_SHIFT(6)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .locked_i       (locked_i),
    .bitperiod_bi   (bitperiod_bi),
    .rx_done_tick_i (rx_done_tick_i),
    .rx_data_bi     (rx_data_bi),
    .req_o          (req_o),
    .we_o           (we_o),
    .addr_bo        (addr_bo),
    .wdata_bo       (wdata_bo),
    .ack_i          (ack_i),
    .err_tick_o     (err_tick_o),
    .overrun_tick_o (overrun_tick_o)
  );

  // Count every cycle a pulse output is high, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (err_tick_o)     err_seen++;
    if (overrun_tick_o) ovr_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_bi     = b;
    rx_done_tick_i = 1'b1;
    @(negedge clk);
    rx_done_tick_i = 1'b0;
  endtask

  task automatic send_seq(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b1;
    locked_i       = 1'b1;
    bitperiod_bi   = 29'd100;
    rx_done_tick_i = 1'b0;
    rx_data_bi     = 8'h00;
    ack_i          = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);

    check("reset_req",   {63'd0, req_o},          64'd0);
    check("reset_we",    {63'd0, we_o},           64'd0);
    check("reset_addr",  {32'd0, addr_bo},        64'd0);
    check("reset_wdata", {32'd0, wdata_bo},       64'd0);
    check("reset_err",   {63'd0, err_tick_o},     64'd0);
    check("reset_ovr",   {63'd0, overrun_tick_o}, 64'd0);

    // Write frame, held for five cycles before the ack.
    err_base = err_seen;
    ovr_base = ovr_seen;
    seq = '{8'h55, 8'h81, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD};
    send_seq(seq);
    check("wr_req_before_last", {63'd0, req_o}, 64'd0);
    send_byte(8'hDE);
    check("wr_req_latency", {63'd0, req_o},    64'd1);
    check("wr_we",          {63'd0, we_o},     64'd1);
    check("wr_addr",        {32'd0, addr_bo},  64'h12345678);
    check("wr_wdata",       {32'd0, wdata_bo}, 64'hDEADBEEF);
    repeat (5) @(negedge clk);
    check("wr_hold_req",   {63'd0, req_o},    64'd1);
    check("wr_hold_we",    {63'd0, we_o},     64'd1);
    check("wr_hold_addr",  {32'd0, addr_bo},  64'h12345678);
    check("wr_hold_wdata", {32'd0, wdata_bo}, 64'hDEADBEEF);
    do_ack();
    check("wr_req_after_ack", {63'd0, req_o}, 64'd0);
    check("wr_no_err", 64'(err_seen - err_base), 64'd0);

    // Escaped read: 5A 55 and 5A 5A become literal address bytes.
    seq = '{8'h55, 8'h82, 8'h5A, 8'h55, 8'h00, 8'h5A, 8'h5A, 8'h00};
    send_seq(seq);
    check("esc_req",  {63'd0, req_o},   64'd1);
    check("esc_we",   {63'd0, we_o},    64'd0);
    check("esc_addr", {32'd0, addr_bo}, 64'h005A0055);
    @(negedge clk);
    check("esc_no_err", 64'(err_seen - err_base), 64'd0);
    check("esc_no_ovr", 64'(ovr_seen - ovr_base), 64'd0);
    do_ack();
    check("esc_req_after_ack", {63'd0, req_o}, 64'd0);

    // Resync mid-address, then a single read request.
    seq = '{8'h55, 8'h81, 8'h11, 8'h55, 8'h82, 8'h00, 8'h00, 8'h00};
    send_seq(seq);
    check("resync_no_early_req", {63'd0, req_o}, 64'd0);
    send_byte(8'h80);
    check("resync_req",  {63'd0, req_o},   64'd1);
    check("resync_we",   {63'd0, we_o},    64'd0);
    check("resync_addr", {32'd0, addr_bo}, 64'h80000000);
    do_ack();

    // Unknown command, then bytes that must be ignored in IDLE.
    err_base = err_seen;
    seq = '{8'h55, 8'h33};
    send_seq(seq);
    @(negedge clk);
    check("badcmd_err_count", 64'(err_seen - err_base), 64'd1);
    seq = '{8'h82, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(seq);
    check("badcmd_idle_no_req", {63'd0, req_o}, 64'd0);

    // Timeout: limit = 10 << 6 = 640 cycles after the last tick.
    bitperiod_bi = 29'd10;
    err_base = err_seen;
    seq = '{8'h55, 8'h81, 8'h12};
    send_seq(seq);
    repeat (639) @(negedge clk);
    check("timeout_not_early", {63'd0, err_tick_o}, 64'd0);
    @(negedge clk);
    check("timeout_pulse", {63'd0, err_tick_o}, 64'd1);
    @(negedge clk);
    check("timeout_pulse_width", {63'd0, err_tick_o}, 64'd0);
    check("timeout_err_count", 64'(err_seen - err_base), 64'd1);
    seq = '{8'h55, 8'h82, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(seq);
    check("post_timeout_req",  {63'd0, req_o},   64'd1);
    check("post_timeout_we",   {63'd0, we_o},    64'd0);
    check("post_timeout_addr", {32'd0, addr_bo}, 64'h04030201);
    do_ack();
    bitperiod_bi = 29'd100;

    // Overrun: a sync byte arriving while the request is held.
    seq = '{8'h55, 8'h82, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_seq(seq);
    check("ovr_req", {63'd0, req_o}, 64'd1);
    ovr_base = ovr_seen;
    send_byte(8'h55);
    check("ovr_pulse", {63'd0, overrun_tick_o}, 64'd1);
    @(negedge clk);
    check("ovr_pulse_width", {63'd0, overrun_tick_o}, 64'd0);
    check("ovr_count",    64'(ovr_seen - ovr_base), 64'd1);
    check("ovr_req_held", {63'd0, req_o},   64'd1);
    check("ovr_addr",     {32'd0, addr_bo}, 64'hDDCCBBAA);
    check("ovr_we",       {63'd0, we_o},    64'd0);
    do_ack();
    seq = '{8'h82, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(seq);
    check("ovr_idle_after_ack", {63'd0, req_o}, 64'd0);

    // Lock loss mid-address drops the frame.
    err_base = err_seen;
    seq = '{8'h55, 8'h81, 8'h01, 8'h02};
    send_seq(seq);
    @(negedge clk);
    locked_i = 1'b0;
    @(negedge clk);
    locked_i = 1'b1;
    seq = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    send_seq(seq);
    check("unlock_no_req", {63'd0, req_o}, 64'd0);
    check("unlock_no_err", 64'(err_seen - err_base), 64'd0);

    // Reset mid-data discards everything.
    seq = '{8'h55, 8'h81, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};
    send_seq(seq);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_mid_we",    {63'd0, we_o},     64'd0);
    check("rst_mid_addr",  {32'd0, addr_bo},  64'd0);
    check("rst_mid_wdata", {32'd0, wdata_bo}, 64'd0);
    seq = '{8'h88, 8'h99};
    send_seq(seq);
    check("rst_mid_no_req", {63'd0, req_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
